// File: rtl/clz_seq_ctrl_pkg.sv
// clz_seq_ctrl_pkg: shared opcodes, FSM state encoding and count width for the CLZ/CLO engine
package clz_seq_ctrl_pkg;
    localparam logic OP_CLZ = 1'b0;
    localparam logic OP_CLO = 1'b1;
    localparam int   CNT_W  = 6;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/clz_seq_ctrl_if.sv
// clz_seq_ctrl_if: request/result bundle between two requesters, the CLZ/CLO engine and its consumer
//   req0_*/req1_* : valid/op/data in, ready back; out_* : valid/count/id out, ready in; busy out
//   master = requesters + consumer side, slave = engine side
interface clz_seq_ctrl_if;
    logic        req0_valid;
    logic        req0_op;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic        req1_op;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_count;
    logic        out_id;
    logic        busy;
    modport master (
        output req0_valid, req0_op, req0_data, req1_valid, req1_op, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_count, out_id, busy
    );
    modport slave (
        input  req0_valid, req0_op, req0_data, req1_valid, req1_op, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_count, out_id, busy
    );
endinterface

// File: rtl/clz_seq_ctrl_lz_slice.sv
// lz_slice: combinational leading-zero count of one W-bit slice
//   slice_i : slice to encode, MSB first
//   count_o : leading zeros, 0..W (W when the slice is all zero)
module lz_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0]             slice_i,
    output logic [$clog2(W+1)-1:0]   count_o
);
    localparam int CW = $clog2(W + 1);
    // Walk upward so the highest set bit is the last (and winning) assignment.
    always_comb begin
        count_o = CW'(W);
        for (int i = 0; i < W; i++)
            if (slice_i[i]) count_o = CW'(W - 1 - i);
    end
endmodule

// File: rtl/clz_seq_ctrl.sv
// clz_seq_ctrl: shared multi-cycle CLZ/CLO engine with round-robin arbitration of two requesters
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of clz_seq_ctrl_if (two request channels, one result channel, busy)
module clz_seq_ctrl
    import clz_seq_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8
) (
    input logic           clk,
    input logic           rst,
    clz_seq_ctrl_if.slave bus
);
    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int IDX_W  = $clog2(NSLICE);
    localparam int LZ_W   = $clog2(SLICE_W + 1);
    state_t              state_q;
    logic [DATA_W-1:0]   opnd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic                id_q;
    logic                last_grant_q;
    logic                idle;
    logic                grant0;
    logic                grant1;
    logic                sel_op;
    logic [DATA_W-1:0]   sel_data;
    logic [SLICE_W-1:0]  slice;
    logic [LZ_W-1:0]     slice_lz;
    // Readies are held low during reset so nothing is accepted by an engine about to be cleared.
    assign idle     = (state_q == ST_IDLE) && !rst;
    assign grant0   = idle && bus.req0_valid && (!bus.req1_valid || last_grant_q);
    assign grant1   = idle && bus.req1_valid && !grant0;
    assign sel_op   = grant1 ? bus.req1_op : bus.req0_op;
    assign sel_data = grant1 ? bus.req1_data : bus.req0_data;
    assign slice    = opnd_q[idx_q*SLICE_W +: SLICE_W];
    lz_slice #(.W(SLICE_W)) u_lz (
        .slice_i (slice),
        .count_o (slice_lz)
    );
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.out_valid  = state_q == ST_DONE;
    assign bus.out_count  = {{(DATA_W-CNT_W){1'b0}}, cnt_q};
    assign bus.out_id     = id_q;
    assign bus.busy       = state_q != ST_IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            opnd_q       <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (grant0 || grant1) begin
                    // CLO is CLZ of the inverted operand.
                    opnd_q       <= sel_data ^ {DATA_W{sel_op == OP_CLO}};
                    id_q         <= grant1;
                    cnt_q        <= '0;
                    idx_q        <= IDX_W'(NSLICE - 1);
                    last_grant_q <= grant1;
                    state_q      <= ST_SCAN;
                end
                ST_SCAN: if (slice != '0) begin
                    cnt_q   <= cnt_q + CNT_W'(slice_lz);
                    state_q <= ST_DONE;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(SLICE_W);
                    if (idx_q == '0) state_q <= ST_DONE;
                    else idx_q <= idx_q - 1'b1;
                end
                ST_DONE: if (bus.out_ready) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clz_seq_ctrl.sv
// tb_clz_seq_ctrl: scoreboard bench for clz_seq_ctrl with directed and random traffic
module tb_clz_seq_ctrl;
    import clz_seq_ctrl_pkg::*;
    localparam int SW = 8;
    localparam int NS = 32 / SW;
    typedef struct {
        logic id;
        int   cnt;
        int   due;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    logic mdl_idle = 1'b1;
    logic mdl_last = 1'b1;
    logic s0, s1;
    int   first;
    int   acc_n;
    clz_seq_ctrl_if bus();
    clz_seq_ctrl #(.DATA_W(32), .SLICE_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endfunction
    function automatic int ref_lc(logic op, logic [31:0] d);
        logic [31:0] x = op ? ~d : d;
        for (int i = 31; i >= 0; i--)
            if (x[i]) return 31 - i;
        return 32;
    endfunction
    // Monitor: reference arbitration, busy tracking and result scoreboard.
    always @(negedge clk) begin
        logic eg0, eg1, exp_ov;
        int lc, k;
        if (rst) begin
            chk("ready0_in_rst", bus.req0_ready, 0);
            chk("ready1_in_rst", bus.req1_ready, 0);
            q.delete();
            mdl_idle = 1'b1;
            mdl_last = 1'b1;
        end else begin
            eg0 = mdl_idle && bus.req0_valid && (!bus.req1_valid || mdl_last);
            eg1 = mdl_idle && bus.req1_valid && !eg0;
            chk("ready0", bus.req0_ready, eg0);
            chk("ready1", bus.req1_ready, eg1);
            chk("busy", bus.busy, !mdl_idle);
            exp_ov = q.size() > 0 && cyc >= q[0].due;
            chk("out_valid", bus.out_valid, exp_ov);
            if (exp_ov) begin
                chk("out_count", bus.out_count, q[0].cnt);
                chk("out_id", bus.out_id, q[0].id);
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    mdl_idle = 1'b1;
                end
            end
            if (eg0 || eg1) begin
                lc = eg1 ? ref_lc(bus.req1_op, bus.req1_data) : ref_lc(bus.req0_op, bus.req0_data);
                k = lc / SW + 1;
                if (k > NS) k = NS;
                q.push_back('{id: eg1, cnt: lc, due: cyc + 1 + k});
                mdl_idle = 1'b0;
                mdl_last = eg1;
            end
        end
    end
    task automatic cycle();
        @(negedge clk);
        s0 = bus.req0_valid && bus.req0_ready;
        s1 = bus.req1_valid && bus.req1_ready;
        @(posedge clk);
        #1;
        if (s0) bus.req0_valid = 1'b0;
        if (s1) bus.req1_valid = 1'b0;
    endtask
    task automatic set_req(int p, logic op, logic [31:0] d);
        if (p == 0) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_data = d;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_data = d;
        end
    endtask
    task automatic drain_reqs(string nm);
        int n = 0;
        first = -1;
        while ((bus.req0_valid || bus.req1_valid) && n < 200) begin
            cycle();
            if (first < 0 && s0) first = 0;
            else if (first < 0 && s1) first = 1;
            n++;
        end
        if (n >= 200) chk({nm, "_accept_timeout"}, 1, 0);
    endtask
    task automatic wait_idle(string nm);
        int n = 0;
        while (!(q.size() == 0 && !bus.busy && !bus.req0_valid && !bus.req1_valid) && n < 200) begin
            cycle();
            n++;
        end
        if (n >= 200) chk({nm, "_idle_timeout"}, 1, 0);
    endtask
    task automatic one(string nm, int p, logic op, logic [31:0] d);
        set_req(p, op, d);
        drain_reqs(nm);
        wait_idle(nm);
    endtask
    initial begin
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_data = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_data = 0;
        bus.out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_count", bus.out_count, 0);
        chk("rst_out_id", bus.out_id, 0);
        chk("rst_busy", bus.busy, 0);
        one("clz_msb", 0, OP_CLZ, 32'h8000_0000);
        one("clz_zero", 1, OP_CLZ, 32'h0000_0000);
        one("clo_ones", 0, OP_CLO, 32'hFFFF_FFFF);
        one("clz_15", 1, OP_CLZ, 32'h0001_0000);
        one("clo_12", 1, OP_CLO, 32'hFFF0_1234);
        for (int r = 0; r < 2; r++) begin
            set_req(0, OP_CLZ, 32'h0000_0F00 << r);
            set_req(1, OP_CLO, 32'hFF00_0000 >> r);
            drain_reqs("rr");
            chk("rr_first_grant", first, 0);
            wait_idle("rr");
        end
        // Backpressure: result held while a fresh req0 waits.
        bus.out_ready = 0;
        set_req(0, OP_CLZ, 32'h00F0_0000);
        drain_reqs("bp");
        for (int n = 0; n < 50 && !bus.out_valid; n++) cycle();
        set_req(0, OP_CLO, 32'hC000_0000);
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("bp_no_ready", s0, 0);
        end
        bus.out_ready = 1;
        drain_reqs("bp2");
        wait_idle("bp2");
        // Reset during the third SCAN cycle of a zero operand from req0.
        set_req(0, OP_CLZ, 32'h0);
        drain_reqs("rst_mid");
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_out_valid", bus.out_valid, 0);
        chk("rstmid_out_count", bus.out_count, 0);
        set_req(0, OP_CLZ, 32'h0000_0040);
        set_req(1, OP_CLZ, 32'h0000_0001);
        drain_reqs("post_rst");
        chk("post_rst_first_grant", first, 0);
        wait_idle("post_rst");
        // Random traffic with random backpressure.
        acc_n = 0;
        for (int n = 0; n < 4000 && acc_n < 150; n++) begin
            if (!bus.req0_valid && $urandom_range(0, 2) == 0)
                set_req(0, 1'($urandom_range(0, 1)), $urandom >> $urandom_range(0, 32));
            if (!bus.req1_valid && $urandom_range(0, 2) == 0)
                set_req(1, 1'($urandom_range(0, 1)), ~($urandom >> $urandom_range(0, 32)));
            bus.out_ready = $urandom_range(0, 3) != 0;
            cycle();
            acc_n += int'(s0) + int'(s1);
        end
        bus.out_ready = 1;
        drain_reqs("rand");
        wait_idle("rand");
        chk("rand_accepts", acc_n >= 150, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
